// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, bit-serial shifts, optional shift-add multiply.
// Define ALU_SEQ_MUL_EN to enable MUL (ctrl 9); otherwise ctrl 9 is reported illegal.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OpAnd = 4'd0;
  localparam logic [3:0] OpAdd = 4'd1;
  localparam logic [3:0] OpOr  = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpSlt = 4'd5;
  localparam logic [3:0] OpSll = 4'd6;
  localparam logic [3:0] OpSrl = 4'd7;
  localparam logic [3:0] OpSra = 4'd8;
  localparam logic [3:0] OpMul = 4'd9;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_w;    // shift working value, or multiplicand for MUL
  logic [SHW:0]     r_cnt;  // one extra bit so MUL can count WIDTH steps
  logic [WIDTH-1:0] r_s;
  logic             r_zero;
  logic             r_ovf;
  logic             r_ill;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_ill;
  logic             w_multi;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_busy_res;
  logic             w_busy_ovf;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [SHW:0] MulCnt = (SHW+1)'(WIDTH);
  logic [2*WIDTH-1:0] r_acc;  // {partial product high half, remaining multiplier bits}
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_acc_nxt;
`endif

  // Result of an op decided in IDLE from the live inputs.
  always_comb begin
    w_sum   = a + b;
    w_diff  = a - b;
    w_res   = '0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    w_multi = 1'b0;
    case (ctrl)
      OpAnd: w_res = a & b;
      OpAdd: begin
        w_res = w_sum;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpOr:  w_res = a | b;
      OpSub: begin
        w_res = w_diff;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpXor: w_res = a ^ b;
      OpSlt: w_res[0] = $signed(a) < $signed(b);
      OpSll, OpSrl, OpSra: begin
        if (b[SHW-1:0] == '0) w_res = a;
        else                  w_multi = 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
      OpMul: w_multi = 1'b1;
`endif
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_shift = r_w;
    case (r_op)
      OpSll:   w_shift = r_w << 1;
      OpSrl:   w_shift = r_w >> 1;
      OpSra:   w_shift = {r_w[WIDTH-1], r_w[WIDTH-1:1]};
      default: ;
    endcase
    w_busy_res = w_shift;
    w_busy_ovf = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_w} : {(WIDTH+1){1'b0}});
    w_acc_nxt = {w_add, r_acc[WIDTH-1:1]};
    if (r_op == OpMul) begin
      w_busy_res = w_acc_nxt[WIDTH-1:0];
      w_busy_ovf = |w_acc_nxt[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_op    <= '0;
      r_w     <= '0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
      r_ill   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_acc   <= '0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_op <= ctrl;
            r_w  <= a;
            if (w_multi) begin
              r_state <= StBusy;
              r_cnt   <= {1'b0, b[SHW-1:0]};
`ifdef ALU_SEQ_MUL_EN
              if (ctrl == OpMul) r_cnt <= MulCnt;
              r_acc <= {{WIDTH{1'b0}}, b};
`endif
            end else begin
              r_state <= StDone;
              r_s     <= w_res;
              r_zero  <= (w_res == '0);
              r_ovf   <= w_ovf;
              r_ill   <= w_ill;
            end
          end
        end
        StBusy: begin
          r_cnt <= r_cnt - 1'b1;
`ifdef ALU_SEQ_MUL_EN
          if (r_op == OpMul) r_acc <= w_acc_nxt;
          else               r_w   <= w_shift;
`else
          r_w <= w_shift;
`endif
          if (r_cnt == (SHW+1)'(1)) begin
            r_state <= StDone;
            r_s     <= w_busy_res;
            r_zero  <= (w_busy_res == '0);
            r_ovf   <= w_busy_ovf;
            r_ill   <= 1'b0;
          end
        end
        StDone: begin
          if (out_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign s         = r_s;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed corner cases plus random ops
// checked against an arithmetic reference model. Honours ALU_SEQ_MUL_EN like the RTL.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic [3:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        zero, overflow, illegal;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: expected result, flags and number of BUSY cycles.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic [3:0] mc,
                       output logic [15:0] r, output logic ovf, output logic ill,
                       output int lat);
    int sa, sb, t, sh;
    logic [31:0] p;
    sa = $signed(ma);
    sb = $signed(mb);
    sh = int'(mb[3:0]);
    r = '0; ovf = 1'b0; ill = 1'b0; lat = 0;
    case (mc)
      4'd0: r = ma & mb;
      4'd1: begin t = sa + sb; r = 16'(t); ovf = (t > 32767) || (t < -32768); end
      4'd2: r = ma | mb;
      4'd3: begin t = sa - sb; r = 16'(t); ovf = (t > 32767) || (t < -32768); end
      4'd4: r = ma ^ mb;
      4'd5: r = (sa < sb) ? 16'd1 : 16'd0;
      4'd6: begin r = ma << sh; lat = sh; end
      4'd7: begin r = ma >> sh; lat = sh; end
      4'd8: begin r = 16'($signed(ma) >>> sh); lat = sh; end
`ifdef ALU_SEQ_MUL_EN
      4'd9: begin p = 32'(ma) * 32'(mb); r = p[15:0]; ovf = (p[31:16] != 0); lat = 16; end
`endif
      default: ill = 1'b1;
    endcase
  endtask

  task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic [3:0] oc,
                       input int hold);
    logic [15:0] er;
    logic        eo, ei;
    int          el, n;
    model(oa, ob, oc, er, eo, ei, el);
    @(negedge clk);
    a = oa; b = ob; ctrl = oc; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); ctrl = 4'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      check("in_ready_busy", in_ready, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, el);
    check("s", s, er);
    check("zero", zero, er == 16'd0);
    check("overflow", overflow, eo);
    check("illegal", illegal, ei);
    // Stall the consumer and wave unrelated requests at the block.
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); ctrl = 4'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_ready", in_ready, 1'b0);
      check("hold_s", s, er);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_idle", in_ready, 1'b1);
    check("post_valid", out_valid, 1'b0);
    check("post_s", s, er);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s", s, 16'd0);
    check("rst_zero", zero, 1'b1);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ill", illegal, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", in_ready, 1'b1);

    do_op(16'h7FFF, 16'h0001, 4'd1, 0);
    do_op(16'h5555, 16'hAAAA, 4'd2, 3);
    do_op(16'h8000, 16'h0004, 4'd8, 1);
    do_op(16'h1234, 16'h0000, 4'd6, 0);
    do_op(16'd300,  16'd300,  4'd9, 0);
    do_op(16'h8000, 16'h0001, 4'd3, 0);
    do_op(16'hFF9B, 16'h0000, 4'd5, 0);
    do_op(16'hABCD, 16'h1234, 4'd15, 1);
    do_op(16'hF00F, 16'h000F, 4'd7, 0);

    // Reset during the 5th BUSY cycle of a long shift.
    @(negedge clk);
    a = 16'd1; b = 16'd15; ctrl = 4'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy_valid", out_valid, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_idle", in_ready, 1'b1);
    check("abort_s", s, 16'd0);
    check("abort_zero", zero, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", in_ready, 1'b1);
    do_op(16'd0, 16'd0, 4'd1, 0);

    for (int k = 0; k < 120; k++) begin
      do_op(16'($urandom), 16'($urandom), 4'($urandom_range(0, 10)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
